// File: rtl/sdiv_frontend.sv
// sdiv_frontend: signed/unsigned front end for an external unsigned divider.
// It takes one request at a time and turns signed operands into magnitudes.
// It launches the divider and waits a bounded number of cycles for the result.
// It then sign-corrects the result and holds it until the consumer accepts it.
// Optional build macro SDIV_DBZ_BYPASS_EN: a zero divisor skips the divider and
// answers directly with quotient 0xFFFFFFFF and remainder = dividend.
module sdiv_frontend #(
    parameter int unsigned TIMEOUT_CYCLES = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_signed,
    input  logic [31:0] req_dividend,
    input  logic [31:0] req_divisor,
    output logic        div_start,
    output logic [31:0] div_src1,
    output logic [31:0] div_src2,
    input  logic [31:0] div_qut,
    input  logic [31:0] div_rmd,
    input  logic        div_done,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_qut,
    output logic [31:0] resp_rmd,
    output logic        resp_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // The last WAIT cycle index before giving up on the divider.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [7:0]  wait_cnt;
    logic        neg_qut;
    logic        neg_rmd;
    logic        req_fire;
    logic        dbz;
    logic [31:0] dividend_abs;
    logic [31:0] divisor_abs;
    logic [31:0] qut_fix;
    logic [31:0] rmd_fix;

    // Ready is withheld while reset is held, so nothing is accepted during reset.
    assign req_ready  = (state == S_IDLE) && !rst;
    assign req_fire   = req_valid && req_ready;
    assign div_start  = (state == S_START);
    assign resp_valid = (state == S_RESP);

`ifdef SDIV_DBZ_BYPASS_EN
    assign dbz = (req_divisor == 32'd0);
`else
    assign dbz = 1'b0;
`endif

    // Operand magnitudes. 0x80000000 negates to itself, which is its correct unsigned magnitude.
    always_comb begin
        dividend_abs = req_dividend;
        divisor_abs  = req_divisor;
        if (req_signed && req_dividend[31]) begin
            dividend_abs = ~req_dividend + 32'd1;
        end
        if (req_signed && req_divisor[31]) begin
            divisor_abs = ~req_divisor + 32'd1;
        end
    end

    // Sign correction of the unsigned divider result using the flags captured at request time.
    always_comb begin
        qut_fix = div_qut;
        rmd_fix = div_rmd;
        if (neg_qut) begin
            qut_fix = ~div_qut + 32'd1;
        end
        if (neg_rmd) begin
            rmd_fix = ~div_rmd + 32'd1;
        end
    end

    // Main controller: request capture, divider launch, bounded wait, response hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= 8'd0;
            neg_qut  <= 1'b0;
            neg_rmd  <= 1'b0;
            div_src1 <= 32'd0;
            div_src2 <= 32'd0;
            resp_qut <= 32'd0;
            resp_rmd <= 32'd0;
            resp_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    wait_cnt <= 8'd0;
                    if (req_fire) begin
                        if (dbz) begin
                            resp_qut <= 32'hFFFF_FFFF;
                            resp_rmd <= req_dividend;
                            resp_err <= 1'b0;
                            state    <= S_RESP;
                        end else begin
                            div_src1 <= dividend_abs;
                            div_src2 <= divisor_abs;
                            neg_qut  <= req_signed & (req_dividend[31] ^ req_divisor[31]);
                            neg_rmd  <= req_signed & req_dividend[31];
                            state    <= S_START;
                        end
                    end
                end
                S_START: begin
                    wait_cnt <= 8'd0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (div_done) begin
                        resp_qut <= qut_fix;
                        resp_rmd <= rmd_fix;
                        resp_err <= 1'b0;
                        state    <= S_RESP;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        resp_qut <= 32'd0;
                        resp_rmd <= 32'd0;
                        resp_err <= 1'b1;
                        state    <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdiv_frontend.sv
// tb_sdiv_frontend: directed testbench for sdiv_frontend.
// The bench plays the external divider with hand-computed results.
// Define SDIV_DBZ_BYPASS_EN for both bench and RTL to exercise the zero-divisor bypass.
module tb_sdiv_frontend;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_signed;
    logic [31:0] req_dividend;
    logic [31:0] req_divisor;
    logic        div_start;
    logic [31:0] div_src1;
    logic [31:0] div_src2;
    logic [31:0] div_qut;
    logic [31:0] div_rmd;
    logic        div_done;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_qut;
    logic [31:0] resp_rmd;
    logic        resp_err;

    int checks;
    int failures;

    sdiv_frontend #(.TIMEOUT_CYCLES(48)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_signed   (req_signed),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .div_start    (div_start),
        .div_src1     (div_src1),
        .div_src2     (div_src2),
        .div_qut      (div_qut),
        .div_rmd      (div_rmd),
        .div_done     (div_done),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_qut     (resp_qut),
        .resp_rmd     (resp_rmd),
        .resp_err     (resp_err)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // Presents one request at a negedge and releases it once the handshake edge has passed.
    task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_signed   = sgn;
        req_dividend = a;
        req_divisor  = b;
        @(negedge clk);
        req_valid    = 1'b0;
    endtask

    // Full transaction through the divider path with optional divider delay and response backpressure.
    task automatic runDiv(input string name, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_src1, input logic [31:0] exp_src2,
                          input logic [31:0] dq, input logic [31:0] dr,
                          input logic [31:0] exp_q, input logic [31:0] exp_r,
                          input int delay, input int hold);
        applyStimulus(sgn, a, b);
        checkOutput({name, "_start"}, 32'(div_start), 32'd1);
        checkOutput({name, "_src1"}, div_src1, exp_src1);
        checkOutput({name, "_src2"}, div_src2, exp_src2);
        checkOutput({name, "_rv_start"}, 32'(resp_valid), 32'd0);
        @(negedge clk);
        checkOutput({name, "_start_pulse"}, 32'(div_start), 32'd0);
        repeat (delay) @(negedge clk);
        checkOutput({name, "_src1_wait"}, div_src1, exp_src1);
        checkOutput({name, "_rv_wait"}, 32'(resp_valid), 32'd0);
        div_done = 1'b1;
        div_qut  = dq;
        div_rmd  = dr;
        @(negedge clk);
        div_done = 1'b0;
        div_qut  = 32'hDEAD_BEEF;
        div_rmd  = 32'hDEAD_BEEF;
        checkOutput({name, "_rv"}, 32'(resp_valid), 32'd1);
        checkOutput({name, "_qut"}, resp_qut, exp_q);
        checkOutput({name, "_rmd"}, resp_rmd, exp_r);
        checkOutput({name, "_err"}, 32'(resp_err), 32'd0);
        checkOutput({name, "_rdy_resp"}, 32'(req_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            req_valid    = 1'b1;
            req_dividend = 32'd77;
            req_divisor  = 32'd3;
            div_done     = (i % 2 == 0);
            @(negedge clk);
            checkOutput({name, "_hold_rv"}, 32'(resp_valid), 32'd1);
            checkOutput({name, "_hold_qut"}, resp_qut, exp_q);
            checkOutput({name, "_hold_rmd"}, resp_rmd, exp_r);
            checkOutput({name, "_hold_rdy"}, 32'(req_ready), 32'd0);
            checkOutput({name, "_hold_start"}, 32'(div_start), 32'd0);
        end
        req_valid  = 1'b0;
        div_done   = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checkOutput({name, "_rv_after"}, 32'(resp_valid), 32'd0);
        checkOutput({name, "_rdy_after"}, 32'(req_ready), 32'd1);
    endtask

    // Directed test sequence.
    initial begin
        int n;
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_signed   = 1'b0;
        req_dividend = 32'd0;
        req_divisor  = 32'd0;
        div_qut      = 32'd0;
        div_rmd      = 32'd0;
        div_done     = 1'b0;
        resp_ready   = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_div_start", 32'(div_start), 32'd0);
        checkOutput("rst_src1", div_src1, 32'd0);
        checkOutput("rst_src2", div_src2, 32'd0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_qut", resp_qut, 32'd0);
        checkOutput("rst_rmd", resp_rmd, 32'd0);
        checkOutput("rst_err", 32'(resp_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ready", 32'(req_ready), 32'd1);

        runDiv("u100_7", 1'b0, 32'd100, 32'd7, 32'd100, 32'd7, 32'd14, 32'd2, 32'd14, 32'd2, 2, 0);
        runDiv("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'd7, 32'd2, 32'd3, 32'd1,
               32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 0);
        runDiv("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1,
               32'h8000_0000, 32'd0, 32'h8000_0000, 32'd0, 3, 0);
        runDiv("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd7, 32'd2, 32'd3, 32'd1,
               32'hFFFF_FFFD, 32'd1, 1, 0);
        runDiv("u_big_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1,
               32'h7FFF_FFFC, 32'd1, 0, 0);
        runDiv("bp_50_5", 1'b0, 32'd50, 32'd5, 32'd50, 32'd5, 32'd10, 32'd0, 32'd10, 32'd0, 1, 10);
        runDiv("b2b_9_4", 1'b0, 32'd9, 32'd4, 32'd9, 32'd4, 32'd2, 32'd1, 32'd2, 32'd1, 0, 0);

        // Divider never answers: the response must come after exactly 48 WAIT cycles with an error.
        applyStimulus(1'b0, 32'd9, 32'd3);
        checkOutput("to_start", 32'(div_start), 32'd1);
        n = 0;
        @(negedge clk);
        while (resp_valid !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checkOutput("to_wait_cycles", 32'(n), 32'd48);
        checkOutput("to_rv", 32'(resp_valid), 32'd1);
        checkOutput("to_err", 32'(resp_err), 32'd1);
        checkOutput("to_qut", resp_qut, 32'd0);
        checkOutput("to_rmd", resp_rmd, 32'd0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checkOutput("to_rv_after", 32'(resp_valid), 32'd0);

        // Reset in the middle of WAIT, then a late div_done that must be ignored.
        applyStimulus(1'b0, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("mr_req_ready", 32'(req_ready), 32'd0);
        checkOutput("mr_src1", div_src1, 32'd0);
        checkOutput("mr_src2", div_src2, 32'd0);
        checkOutput("mr_rv", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        div_done = 1'b1;
        div_qut  = 32'd14;
        div_rmd  = 32'd2;
        @(negedge clk);
        div_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("mr_late_rv", 32'(resp_valid), 32'd0);
            checkOutput("mr_late_start", 32'(div_start), 32'd0);
            checkOutput("mr_late_ready", 32'(req_ready), 32'd1);
            checkOutput("mr_late_qut", resp_qut, 32'd0);
            checkOutput("mr_late_err", 32'(resp_err), 32'd0);
            checkOutput("mr_late_src1", div_src1, 32'd0);
            @(negedge clk);
        end

        // Zero divisor with dividend 5.
`ifdef SDIV_DBZ_BYPASS_EN
        applyStimulus(1'b0, 32'd5, 32'd0);
        checkOutput("dbz_no_start", 32'(div_start), 32'd0);
        checkOutput("dbz_rv", 32'(resp_valid), 32'd1);
        checkOutput("dbz_qut", resp_qut, 32'hFFFF_FFFF);
        checkOutput("dbz_rmd", resp_rmd, 32'd5);
        checkOutput("dbz_err", 32'(resp_err), 32'd0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checkOutput("dbz_rdy_after", 32'(req_ready), 32'd1);
`else
        runDiv("dbz_div", 1'b0, 32'd5, 32'd0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5,
               32'hFFFF_FFFF, 32'd5, 1, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdiv_frontend.md
SDIV_FRONTEND -- requirements
Module: sdiv_frontend

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 48, max cycles in WAIT before abort (range 34..255).
REQ-002 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, request present.
REQ-005 SHALL have port req_ready, output, 1, block can accept a request.
REQ-006 SHALL have port req_signed, input, 1, 1 = two's-complement operands, 0 = unsigned.
REQ-007 SHALL have port req_dividend, input, 32, dividend.
REQ-008 SHALL have port req_divisor, input, 32, divisor.
REQ-009 SHALL have port div_start, output, 1, one-cycle launch pulse to the unsigned divider.
REQ-010 SHALL have ports div_src1 / div_src2, output, 32 each, unsigned dividend / divisor magnitudes.
REQ-011 SHALL have ports div_qut / div_rmd, input, 32 each, unsigned divider results.
REQ-012 SHALL have port div_done, input, 1, one-cycle divider completion pulse.
REQ-013 SHALL have port resp_valid, output, 1, result present.
REQ-014 SHALL have port resp_ready, input, 1, consumer accepts result.
REQ-015 SHALL have ports resp_qut / resp_rmd, output, 32 each, final quotient / remainder.
REQ-016 SHALL have port resp_err, output, 1, set with resp_valid when the divider timed out.

Function
REQ-017 SHALL implement FSM IDLE -> START -> WAIT -> RESP -> IDLE.
REQ-018 SHALL assert req_ready only in IDLE; handshake req_valid&req_ready moves IDLE->START and registers the operands.
REQ-019 SHALL in signed mode register div_src1=|dividend| and div_src2=|divisor| (32-bit two's-complement negation; 0x80000000 stays 0x80000000), plus sign flags; in unsigned mode pass operands unchanged.
REQ-020 SHALL assert div_start for exactly the one START cycle, then move to WAIT; div_src1/div_src2 SHALL stay stable from START until leaving WAIT.
REQ-021 SHALL in WAIT on div_done=1 register the corrected results and move to RESP; resp_valid rises the cycle after div_done.
REQ-022 SHALL, for signed mode, negate the quotient when the operand signs differ and give the remainder the dividend's sign; 0x80000000 / 0xFFFFFFFF yields qut=0x80000000, rmd=0.
REQ-023 SHALL count WAIT cycles; on reaching TIMEOUT_CYCLES without div_done go to RESP with resp_err=1, resp_qut=resp_rmd=0.
REQ-024 SHALL hold resp_valid and all resp_* stable in RESP until resp_ready=1, then return to IDLE; back-to-back: req_ready is 1 the cycle after the response handshake.
REQ-025 SHALL ignore div_done outside WAIT and req_valid outside IDLE.
REQ-026 SHALL keep div_start=0 and resp_valid=0 in every state other than START and RESP respectively.

Reset
REQ-027 SHALL on rst=1, asynchronously at any state: FSM=IDLE, req_ready=0 while rst is asserted (1 on the first cycle after release), div_start=0, div_src1=div_src2=0, resp_valid=0, resp_qut=resp_rmd=0, resp_err=0, timeout counter=0.
REQ-028 SHALL drop any in-flight operation on reset mid-operation; a late div_done after release SHALL be ignored (REQ-025).

Configuration
REQ-029 SHALL honour macro SDIV_DBZ_BYPASS_EN: when defined, a divisor of 0 bypasses START/WAIT (IDLE->RESP next cycle) with resp_qut=0xFFFFFFFF, resp_rmd=dividend, resp_err=0, and no div_start.
REQ-030 SHALL without SDIV_DBZ_BYPASS_EN issue a zero divisor to the divider like any other value and return its result with sign correction applied.

Verification
REQ-031 SHALL cover unsigned 100/7 -> div_src1=100, div_src2=7, one div_start pulse, resp_qut=14, resp_rmd=2.
REQ-032 SHALL cover signed -7/2 (0xFFFFFFF9/2) -> div_src1=7, resp_qut=0xFFFFFFFD, resp_rmd=0xFFFFFFFF; signed 0x80000000/0xFFFFFFFF -> qut=0x80000000, rmd=0.
REQ-033 SHALL cover resp_ready held low 10 cycles -> resp_valid and data stable, req_ready=0; new request accepted the cycle after the handshake.
REQ-034 SHALL cover div_done withheld -> resp_valid with resp_err=1 after 48 WAIT cycles.
REQ-035 SHALL cover rst pulse in WAIT, then a stray div_done -> no resp_valid, all outputs at reset values.
REQ-036 SHALL cover divisor 0 with dividend 5: with SDIV_DBZ_BYPASS_EN -> no div_start, qut=0xFFFFFFFF, rmd=5; without it -> div_start issued.
